// File: rtl/rcpu_mem_responder_if.sv
// RCPU memory-bus signals (CPU side) bundled with the external SRAM req/ack port.
// The slave modport is the responder's view; master is the surrounding CPU + SRAM.
interface rcpu_mem_responder_if #(
    parameter int M      = 16,
    parameter int N      = 32,
    parameter int ADDR_W = 20
);
    logic [N-1:0]      memAddr;
    logic [M-1:0]      memWrite;
    logic              memRE;
    logic              memWE;
    logic [M-1:0]      memRead;
    logic              memReady;
    logic              sram_req;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [M-1:0]      sram_wdata;
    logic [M-1:0]      sram_rdata;
    logic              sram_ack;

    // Handshakes: memRE stays high until the single-cycle memReady pulse; memWE is one
    // cycle per write. sram_req and its we/addr/wdata stay stable until the one-cycle
    // sram_ack, and sram_rdata is only meaningful in the cycle sram_ack is high.
    modport master (
        output memAddr, memWrite, memRE, memWE, sram_rdata, sram_ack,
        input  memRead, memReady, sram_req, sram_we, sram_addr, sram_wdata
    );

    modport slave (
        input  memAddr, memWrite, memRE, memWE, sram_rdata, sram_ack,
        output memRead, memReady, sram_req, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/rcpu_mem_responder.sv
// RCPU memory-bus responder: posts CPU writes into a small FIFO and drains them to a
// req/ack SRAM; reads stall the CPU and are ordered behind every earlier posted write.
module rcpu_mem_responder #(
    parameter int M          = 16,
    parameter int N          = 32,
    parameter int ADDR_W     = 20,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    rcpu_mem_responder_if.slave  bus,
    output logic                 wbuf_overflow,
    output logic                 proto_err,
    output logic [1:0]           o_dbg_state
);
    localparam int              PW      = $clog2(WBUF_DEPTH) + 1;
    localparam logic [PW-1:0]   PTR_ONE = PW'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WR_BUSY = 2'd1,
        S_RD_BUSY = 2'd2,
        S_RD_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [M-1:0]      r_wdata;
    logic [M-1:0]      r_rdata;
    logic              r_ready;
    logic              r_ovf;
    logic              r_perr;
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [ADDR_W-1:0] r_fifo_addr [WBUF_DEPTH];
    logic [M-1:0]      r_fifo_data [WBUF_DEPTH];

    logic              w_req_nxt;
    logic              w_we_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [M-1:0]      w_wdata_nxt;
    logic [M-1:0]      w_rdata_nxt;
    logic              w_ready_nxt;
    logic              w_pop;
    logic              w_in_range;
    logic              w_empty;
    logic              w_full;
    logic              w_wr_req;
    logic              w_push;
    logic              w_drop;
    logic [PW-2:0]     w_head_idx;
    logic [PW-2:0]     w_tail_idx;

    assign w_in_range = (bus.memAddr[N-1:ADDR_W] == '0);
    assign w_head_idx = r_rd_ptr[PW-2:0];
    assign w_tail_idx = r_wr_ptr[PW-2:0];
    // The extra top pointer bit separates "full" from "empty" when the indices match.
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) && (w_tail_idx == w_head_idx);

    // A simultaneous read wins: the write half of a memRE+memWE cycle is discarded.
    assign w_wr_req   = bus.memWE && !bus.memRE && w_in_range;
    assign w_push     = w_wr_req && (!w_full || w_pop);
    assign w_drop     = w_wr_req && w_full && !w_pop;

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_rdata_nxt = r_rdata;
        w_ready_nxt = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_req_nxt   = 1'b1;
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = r_fifo_addr[w_head_idx];
                    w_wdata_nxt = r_fifo_data[w_head_idx];
                    w_state_nxt = S_WR_BUSY;
                end else if (bus.memRE) begin
                    if (w_in_range) begin
                        w_req_nxt   = 1'b1;
                        w_we_nxt    = 1'b0;
                        w_addr_nxt  = bus.memAddr[ADDR_W-1:0];
                        w_state_nxt = S_RD_BUSY;
                    end else begin
                        w_rdata_nxt = '0;
                        w_ready_nxt = 1'b1;
                        w_state_nxt = S_RD_DONE;
                    end
                end
            end
            S_WR_BUSY: begin
                if (bus.sram_ack) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            S_RD_BUSY: begin
                if (bus.sram_ack) begin
                    w_req_nxt   = 1'b0;
                    w_rdata_nxt = bus.sram_rdata;
                    w_ready_nxt = 1'b1;
                    w_state_nxt = S_RD_DONE;
                end
            end
            // memRE is still high here for the read just completed; it is not re-issued.
            S_RD_DONE: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ready <= 1'b0;
            r_ovf   <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_rdata <= w_rdata_nxt;
            r_ready <= w_ready_nxt;
            if (w_drop) r_ovf <= 1'b1;
            if (bus.memRE && bus.memWE) r_perr <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Storage needs no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[w_tail_idx] <= bus.memAddr[ADDR_W-1:0];
            r_fifo_data[w_tail_idx] <= bus.memWrite;
        end
    end

    assign bus.memRead    = r_rdata;
    assign bus.memReady   = r_ready;
    assign bus.sram_req   = r_req;
    assign bus.sram_we    = r_we;
    assign bus.sram_addr  = r_addr;
    assign bus.sram_wdata = r_wdata;
    assign wbuf_overflow  = r_ovf;
    assign proto_err      = r_perr;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_rcpu_mem_responder.sv
// Bench for rcpu_mem_responder: table of single transactions, hand-built corner sequences,
// and a randomized run checked against a memory-map reference model and an SRAM scoreboard.
module tb_rcpu_mem_responder;
    localparam int M     = 16;
    localparam int N     = 32;
    localparam int AW    = 20;
    localparam int DEPTH = 4;
    localparam int W     = 1 + AW + M;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wbuf_overflow;
    logic       proto_err;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    rcpu_mem_responder_if #(.M(M), .N(N), .ADDR_W(AW)) bus ();

    rcpu_mem_responder #(.M(M), .N(N), .ADDR_W(AW), .WBUF_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .wbuf_overflow (wbuf_overflow),
        .proto_err     (proto_err),
        .o_dbg_state   (dbg_state)
    );

    typedef struct {
        bit          is_rd;
        logic [31:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        int          exp_lat;
    } vec_t;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] exp_q [$];
    logic [M-1:0] ref_mem [int];
    logic [M-1:0] sram_mem [int];
    bit           ack_en = 1'b1;
    int           fixed_lat = 0;
    int           late_req = 0;
    int           wr_ack_cnt = 0;
    longint       last_wr_ack_t = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Power-up SRAM contents for words never written.
    function automatic logic [M-1:0] dflt(input int a);
        logic [31:0] av;
        av = a;
        return av[15:0] ^ 16'hA5A5;
    endfunction

    function automatic bit in_rng(input logic [31:0] a);
        return a[31:AW] == '0;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [15:0] d, input bit exp_drop);
        bus.memAddr  = a;
        bus.memWrite = d;
        bus.memRE    = 1'b0;
        bus.memWE    = 1'b1;
        if (in_rng(a) && !exp_drop) begin
            ref_mem[int'(a[AW-1:0])] = d;
            exp_q.push_back({1'b1, a[AW-1:0], d});
        end
        @(posedge clk);
        #1;
        bus.memWE = 1'b0;
    endtask

    task automatic cpu_read(input logic [31:0] a, input bit with_we,
                            output logic [15:0] data, output int lat, output longint t_ready);
        logic [15:0] exp_d;
        bit          got;
        int          idx;
        idx   = int'(a[AW-1:0]);
        exp_d = '0;
        if (in_rng(a)) begin
            exp_d = ref_mem.exists(idx) ? ref_mem[idx] : dflt(idx);
            exp_q.push_back({1'b0, a[AW-1:0], 16'h0000});
        end
        bus.memAddr  = a;
        bus.memWrite = 16'hFACE;
        bus.memWE    = with_we;
        bus.memRE    = 1'b1;
        got = 1'b0;
        lat = 0;
        data = '0;
        t_ready = 0;
        for (int c = 1; c <= 200 && !got; c++) begin
            @(posedge clk);
            #1;
            bus.memWE = 1'b0;
            if (bus.memReady) begin
                got     = 1'b1;
                lat     = c;
                data    = bus.memRead;
                t_ready = $time;
            end
        end
        check("rd_done", 64'(got), 64'd1);
        if (got) check("rd_data", 64'(data), 64'(exp_d));
        @(posedge clk);
        #1;
        bus.memRE = 1'b0;
        check("rd_pulse", 64'(bus.memReady), 64'd0);
    endtask

    // SRAM model plus scoreboard: each new request is matched against exp_q in order.
    initial begin : sram_model
        logic [W-1:0]  exp_t;
        logic [W-1:0]  act_t;
        logic [AW-1:0] l_addr;
        logic [M-1:0]  l_wdata;
        logic          l_we;
        int            wait_cnt;
        bit            in_txn;
        int            late_seen;
        bus.sram_ack   = 1'b0;
        bus.sram_rdata = '0;
        in_txn    = 1'b0;
        late_seen = 0;
        wait_cnt  = 0;
        l_addr    = '0;
        l_wdata   = '0;
        l_we      = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                bus.sram_ack = 1'b0;
                in_txn       = 1'b0;
            end else if (bus.sram_ack) begin
                bus.sram_ack   = 1'b0;
                bus.sram_rdata = 16'($urandom);
                in_txn         = 1'b0;
            end else if (late_req != late_seen) begin
                late_seen      = late_req;
                bus.sram_rdata = 16'h7777;
                bus.sram_ack   = 1'b1;
            end else begin
                if (bus.sram_req && !in_txn) begin
                    in_txn   = 1'b1;
                    l_addr   = bus.sram_addr;
                    l_we     = bus.sram_we;
                    l_wdata  = bus.sram_wdata;
                    wait_cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
                    act_t    = {l_we, l_addr, (l_we ? l_wdata : 16'h0000)};
                    if (exp_q.size() == 0) begin
                        check("sram_txn_expected", 64'(exp_q.size()), 64'd1);
                    end else begin
                        exp_t = exp_q.pop_front();
                        check("sram_txn", 64'(act_t), 64'(exp_t));
                    end
                end
                if (in_txn && ack_en) begin
                    if (wait_cnt == 0) begin
                        check("sram_stable",
                              64'({bus.sram_req, bus.sram_we, bus.sram_addr, bus.sram_wdata}),
                              64'({1'b1, l_we, l_addr, l_wdata}));
                        if (l_we) begin
                            sram_mem[int'(l_addr)] = l_wdata;
                            wr_ack_cnt++;
                            last_wr_ack_t = $time;
                        end else begin
                            bus.sram_rdata = sram_mem.exists(int'(l_addr)) ?
                                             sram_mem[int'(l_addr)] : dflt(int'(l_addr));
                        end
                        bus.sram_ack = 1'b1;
                    end else begin
                        wait_cnt--;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t        vecs [14];
        logic [15:0] d;
        logic [15:0] prev_rd;
        bit          have_prev;
        int          lat;
        longint      tr;
        int          ack_base;
        int          wsr;
        logic [31:0] a;
        int          r;

        vecs[0]  = '{1'b1, 32'h0000_0010, 16'h0000, 16'hBEEF, 2};
        vecs[1]  = '{1'b0, 32'h0000_0020, 16'h0A0A, 16'h0000, 0};
        vecs[2]  = '{1'b0, 32'h0000_0021, 16'h0B0B, 16'h0000, 0};
        vecs[3]  = '{1'b1, 32'h0000_0021, 16'h0000, 16'h0B0B, 2};
        vecs[4]  = '{1'b1, 32'h0000_0020, 16'h0000, 16'h0A0A, 2};
        vecs[5]  = '{1'b1, 32'h0010_0000, 16'h0000, 16'h0000, 1};
        vecs[6]  = '{1'b0, 32'h0010_0000, 16'hDEAD, 16'h0000, 0};
        vecs[7]  = '{1'b1, 32'h0000_0000, 16'h0000, 16'hA5A5, 2};
        vecs[8]  = '{1'b1, 32'h000F_FFFF, 16'h0000, 16'h5A5A, 2};
        vecs[9]  = '{1'b0, 32'h000F_FFFF, 16'h1234, 16'h0000, 0};
        vecs[10] = '{1'b1, 32'h000F_FFFF, 16'h0000, 16'h1234, 2};
        vecs[11] = '{1'b1, 32'h8000_0000, 16'h0000, 16'h0000, 1};
        vecs[12] = '{1'b0, 32'h0000_0021, 16'hC0C0, 16'h0000, 0};
        vecs[13] = '{1'b1, 32'h0000_0021, 16'h0000, 16'hC0C0, 2};

        sram_mem[16'h0010] = 16'hBEEF;
        ref_mem[16'h0010]  = 16'hBEEF;

        bus.memAddr  = '0;
        bus.memWrite = '0;
        bus.memRE    = 1'b0;
        bus.memWE    = 1'b0;

        // Reset state.
        step(3);
        check("rst_outputs",
              64'({bus.memReady, bus.memRead, bus.sram_req, bus.sram_we, bus.sram_addr,
                   bus.sram_wdata, wbuf_overflow, proto_err}), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        rst = 1'b1;
        step(2);

        // Single transactions, FIFO drained before each read, SRAM acks after one cycle.
        fixed_lat = 0;
        have_prev = 1'b0;
        prev_rd   = '0;
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].is_rd) begin
                step(12);
                if (have_prev) check("rd_hold", 64'(bus.memRead), 64'(prev_rd));
                cpu_read(vecs[i].addr, 1'b0, d, lat, tr);
                check("tbl_rd_data", 64'(d), 64'(vecs[i].exp_rd));
                check("tbl_rd_lat", 64'(lat), 64'(vecs[i].exp_lat));
                prev_rd   = d;
                have_prev = 1'b1;
            end else begin
                cpu_write(vecs[i].addr, vecs[i].wdata, 1'b0);
            end
        end
        check("tbl_no_overflow", 64'(wbuf_overflow), 64'd0);
        check("tbl_no_proto", 64'(proto_err), 64'd0);

        // Back-to-back writes, then an immediate read that must wait for all three.
        step(4);
        ack_base = wr_ack_cnt;
        cpu_write(32'h1, 16'h1111, 1'b0);
        cpu_write(32'h2, 16'h2222, 1'b0);
        cpu_write(32'h3, 16'h3333, 1'b0);
        cpu_read(32'h2, 1'b0, d, lat, tr);
        check("b2b_data", 64'(d), 64'h2222);
        check("b2b_writes_first", 64'(wr_ack_cnt - ack_base), 64'd3);
        check("b2b_ready_after_ack", 64'(tr > last_wr_ack_t), 64'd1);

        // Overflow: SRAM stalled, one write in flight, four queued, sixth dropped.
        step(4);
        ack_en = 1'b0;
        for (int i = 0; i < 5; i++) cpu_write(32'h100 + 32'(i), 16'h5000 + 16'(i), 1'b0);
        check("ovf_clear_after5", 64'(wbuf_overflow), 64'd0);
        check("ovf_state_wr_busy", 64'(dbg_state), 64'd1);
        cpu_write(32'h105, 16'h5005, 1'b1);
        check("ovf_set", 64'(wbuf_overflow), 64'd1);
        ack_en = 1'b1;
        step(16);
        cpu_read(32'h104, 1'b0, d, lat, tr);
        check("ovf_fifth_kept", 64'(d), 64'h5004);
        cpu_read(32'h105, 1'b0, d, lat, tr);
        check("ovf_sixth_dropped", 64'(d), 64'(dflt(32'h105)));
        check("ovf_sticky", 64'(wbuf_overflow), 64'd1);

        // memRE and memWE together: write ignored, read proceeds, sticky flag.
        step(3);
        cpu_read(32'h21, 1'b1, d, lat, tr);
        check("proto_read_ok", 64'(d), 64'hC0C0);
        check("proto_set", 64'(proto_err), 64'd1);
        step(6);
        cpu_read(32'h21, 1'b0, d, lat, tr);
        check("proto_write_ignored", 64'(d), 64'hC0C0);

        // Reset in the middle of a read, then a stray ack after release.
        step(3);
        ack_en = 1'b0;
        exp_q.push_back({1'b0, 20'h00030, 16'h0000});
        bus.memAddr = 32'h30;
        bus.memRE   = 1'b1;
        step(2);
        check("mid_rd_req", 64'(bus.sram_req), 64'd1);
        check("mid_rd_state", 64'(dbg_state), 64'd2);
        #2;
        rst = 1'b0;
        bus.memRE = 1'b0;
        #1;
        check("async_rst_outputs",
              64'({bus.memReady, bus.memRead, bus.sram_req, bus.sram_we, bus.sram_addr,
                   bus.sram_wdata, wbuf_overflow, proto_err}), 64'd0);
        step(2);
        rst = 1'b1;
        ack_en = 1'b1;
        late_req++;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("late_ack_ignored",
                  64'({bus.memReady, bus.sram_req, bus.memRead, dbg_state}), 64'd0);
        end

        // Randomized traffic with random SRAM latency; at most DEPTH writes between reads.
        fixed_lat = -1;
        wsr = 0;
        for (int i = 0; i < 120; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)       a = 32'($urandom_range(0, 7));
            else if (r < 9)  a = 32'h000F_FFF8 + 32'($urandom_range(0, 7));
            else             a = 32'h0010_0000 + 32'($urandom_range(0, 15));
            if ($urandom_range(0, 2) != 0 && wsr < DEPTH) begin
                cpu_write(a, 16'($urandom), 1'b0);
                wsr++;
            end else begin
                cpu_read(a, ($urandom_range(0, 15) == 0), d, lat, tr);
                wsr = 0;
            end
            step(int'($urandom_range(0, 2)));
        end

        step(30);
        check("sram_all_seen", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
